// File: rtl/fp_pkg.sv
// fp_pkg: default widths, in_sum bit positions, packed result type and stage-1 classes for fp_norm_round
package fp_pkg;
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam logic [DEF_EXP_W-1:0] EXP_MAX = '1;
  localparam int BIT_HID = DEF_MAN_W + 3;
  localparam int BIT_G = 2;
  localparam int BIT_R = 1;
  localparam int BIT_S = 0;
  typedef struct packed {
    logic sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W-1:0] frac;
  } fp_t;
  typedef enum logic [1:0] {K_NORM, K_SPEC, K_ZERO, K_FLUSH} kind_e;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero count of v (cnt = W when v is zero)
module fp_lzc #(
  parameter int W = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  v,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (v[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: 2-stage normalize + round-to-nearest-even pipeline; in_{valid,ready,sign,exp,sum,co} -> out_{valid,ready,sign,exp,frac,ovf,unf,inexact}
module fp_norm_round import fp_pkg::*; #(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+3:0] in_sum,
  input  logic             in_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_frac,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inexact
);
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  logic s1_valid, s1_sign, s1_adv, s2_adv, g, r, s, ovf, is_norm;
  kind_e s1_kind, k;
  logic signed [XW-1:0] s1_exp, e_adj, e_r;
  logic [SW-1:0] s1_man, m_adj;
  logic [CW-1:0] lz;
  logic [MAN_W:0] rnd;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !rst;
  fp_lzc #(.W(SW)) u_lzc (.v(in_sum), .cnt(lz));
  always_comb begin
    m_adj = in_co ? {1'b1, in_sum[SW-1:2], |in_sum[1:0]} : in_sum << lz;
    e_adj = {2'b0, in_exp} + (in_co ? XW'(1) : -XW'(lz));
    k = &in_exp ? K_SPEC : !(in_co || |in_sum) ? K_ZERO : (e_adj[XW-1] || e_adj == '0) ? K_FLUSH : K_NORM;
    {g, r, s} = {s1_man[BIT_G], s1_man[BIT_R], s1_man[BIT_S]};
    rnd = {1'b0, s1_man[SW-2:3]} + (MAN_W+1)'(g && (r || s || s1_man[3]));
    e_r = s1_exp + XW'(rnd[MAN_W]);
    is_norm = s1_kind == K_NORM;
    ovf = is_norm && e_r >= XW'({EXP_W{1'b1}});
  end
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_sign <= 1'b0;
      out_exp <= '0;
      out_frac <= '0;
      out_ovf <= 1'b0;
      out_unf <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        s1_kind <= k;
        s1_sign <= in_sign;
        s1_exp <= e_adj;
        s1_man <= k == K_SPEC ? in_sum : m_adj;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_sign <= s1_kind != K_ZERO && s1_sign;
        out_exp <= (s1_kind == K_SPEC || ovf) ? '1 : is_norm ? e_r[EXP_W-1:0] : '0;
        out_frac <= s1_kind == K_SPEC ? s1_man[SW-2:3] : (is_norm && !ovf) ? rnd[MAN_W-1:0] : '0;
        out_ovf <= ovf;
        out_unf <= s1_kind == K_FLUSH;
        out_inexact <= s1_kind == K_FLUSH || (is_norm && (g || r || s || ovf));
      end
    end
endmodule
